// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the 5-stage datapath and pipe_hazard_ctrl.
// master = datapath side (reports pipeline state), slave = controller side.
interface pipe_hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1, id_rs2;
  logic              id_use_rs1, id_use_rs2;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic [REG_AW-1:0] mem_rd, wb_rd;
  logic              mem_reg_write, wb_reg_write;
  logic              mem_req, mem_ready;

  logic [1:0]        fwd_a, fwd_b;
  logic              pc_en, pc_sel_branch;
  logic              ifid_en, idex_en, exmem_en;
  logic              ifid_flush, idex_flush;
  logic              memwb_bubble;
  logic              err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_req, mem_ready,
    input  fwd_a, fwd_b, pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, memwb_bubble, err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_req, mem_ready,
    output fwd_a, fwd_b, pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, memwb_bubble, err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the IF/ID/EX/MEM/WB pipeline: forwarding selects,
// load-use stalls, branch flushes, memory-wait freezes and debug counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rst,
  pipe_hazard_if.slave hz
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WCNT_W-1:0]  wait_cnt, wait_nxt;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
  logic               err_q;
  logic               stall_inc, flush_inc;
  logic               load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_wr,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_wr
  );
    if (m_wr && (m_rd != '0) && (m_rd == rs))      return 2'b10;
    else if (w_wr && (w_rd != '0) && (w_rd == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    hz.fwd_a = 2'b00;
    hz.fwd_b = 2'b00;
    if (!rst) begin
      hz.fwd_a = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
      hz.fwd_b = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
    end
  end

  always_comb begin
    state_nxt         = state;
    wait_nxt          = wait_cnt;
    stall_inc         = 1'b0;
    flush_inc         = 1'b0;
    hz.pc_en          = 1'b1;
    hz.pc_sel_branch  = 1'b0;
    hz.ifid_en        = 1'b1;
    hz.idex_en        = 1'b1;
    hz.exmem_en       = 1'b1;
    hz.ifid_flush     = 1'b0;
    hz.idex_flush     = 1'b0;
    hz.memwb_bubble   = 1'b0;

    if (rst) begin
      // Outputs follow reset immediately, without waiting for a clock edge.
      hz.pc_en        = 1'b0;
      hz.ifid_en      = 1'b0;
      hz.idex_en      = 1'b0;
      hz.exmem_en     = 1'b0;
      hz.ifid_flush   = 1'b1;
      hz.idex_flush   = 1'b1;
      hz.memwb_bubble = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.mem_req && !hz.mem_ready) begin
            hz.pc_en        = 1'b0;
            hz.ifid_en      = 1'b0;
            hz.idex_en      = 1'b0;
            hz.exmem_en     = 1'b0;
            hz.memwb_bubble = 1'b1;
            stall_inc       = 1'b1;
            wait_nxt        = WCNT_W'(1);
            state_nxt       = MEM_WAIT;
          end else if (hz.ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use hazard is moot.
            hz.pc_sel_branch = 1'b1;
            hz.ifid_flush    = 1'b1;
            hz.idex_flush    = 1'b1;
            flush_inc        = 1'b1;
          end else if (load_use) begin
            hz.pc_en      = 1'b0;
            hz.ifid_en    = 1'b0;
            hz.idex_flush = 1'b1;
            stall_inc     = 1'b1;
          end
        end
        MEM_WAIT: begin
          hz.pc_en        = 1'b0;
          hz.ifid_en      = 1'b0;
          hz.idex_en      = 1'b0;
          hz.exmem_en     = 1'b0;
          hz.memwb_bubble = 1'b1;
          stall_inc       = 1'b1;
          if (hz.mem_ready) begin
            state_nxt = RUN;
          end else if (wait_cnt == TIMEOUT_V) begin
            state_nxt = ERROR;
          end else begin
            wait_nxt = wait_cnt + WCNT_W'(1);
          end
        end
        default: begin
          hz.pc_en        = 1'b0;
          hz.ifid_en      = 1'b0;
          hz.idex_en      = 1'b0;
          hz.exmem_en     = 1'b0;
          hz.memwb_bubble = 1'b1;
          stall_inc       = 1'b1;
          state_nxt       = ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_q | (state_nxt == ERROR);
      if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_inc) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign hz.err       = err_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule
